// File: rtl/instr_ascii_parser.sv
// -----------------------------------------------------------------------------
// instr_ascii_parser
//   Parses the ASCII light-grid instruction stream (one character per
//   inbound_valid) into fixed-layout instruction words:
//     {opcode[1:0], x0, y0, x1, y1, 2'b00}
//   opcode: 01 turn on, 10 turn off, 11 toggle.
//   Malformed lines set the sticky format_error. A NUL byte ends the input
//   (sticky end_of_file). After that, every byte is ignored until reset.
//
// Ports
//   clk            TCK
//   reset          asynchronous, active-high
//   inbound_valid  inbound_data carries a new character this cycle
//   inbound_data   ASCII character
//   end_of_file    sticky, set once NUL has been accepted
//   instr_valid    one-cycle pulse, instr_data captured this cycle
//   instr_data     instruction word (held until the next capture)
//   format_error   sticky, set on any malformed line
//   instr_count    number of instr_valid pulses, wraps
//
// Optional feature
//   INSTR_NORMALIZE_EN: when defined, the captured word carries
//   x0<=x1 and y0<=y1 (min/max swap in the capture cycle).
// -----------------------------------------------------------------------------
module instr_ascii_parser #(
  parameter int INBOUND_DATA_WIDTH = 8,
  parameter int COORD_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH  = 52,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inbound_valid,
  input  logic [INBOUND_DATA_WIDTH-1:0] inbound_data,
  output logic                          end_of_file,
  output logic                          instr_valid,
  output logic [INSTRUCTION_WIDTH-1:0]  instr_data,
  output logic                          format_error,
  output logic [COUNT_WIDTH-1:0]        instr_count
);

  localparam int AW = COORD_WIDTH + 2;  // room for acc*10 before truncation

  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_NUL = 'h00;
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_LF  = 'h0A;
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_CR  = 'h0D;
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_0   = 'h30;
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_9   = 'h39;
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_F   = 'h66;  // 'f'
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_N   = 'h6E;  // 'n'
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_O   = 'h6F;  // 'o'
  localparam logic [INBOUND_DATA_WIDTH-1:0] CH_U   = 'h75;  // 'u'

  typedef enum logic [1:0] {S_OP, S_NUM, S_SKIP, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [3:0]                         k_q, k_d;        // char index before first digit, saturating
  logic [1:0]                         op_q, op_d;      // 00 = not yet known
  logic                               turn_q, turn_d;  // "tu..." seen, waiting for on/off
  logic [AW-1:0]                      acc_q, acc_d;
  logic [2:0]                         ndig_q, ndig_d;  // digits in the open field
  logic [2:0]                         idx_q, idx_d;    // closed fields
  logic [3:0][COORD_WIDTH-1:0]        fld_q, fld_d;
  logic                               eof_q, eof_d;
  logic                               err_q, err_d;
  logic                               valid_q, valid_d;
  logic [INSTRUCTION_WIDTH-1:0]       data_q, data_d;
  logic [COUNT_WIDTH-1:0]             cnt_q, cnt_d;

  // Line-terminator view: fields as they stand once the open field is closed.
  logic [3:0][COORD_WIDTH-1:0]        fld_close;
  logic [2:0]                         idx_close;
  logic                               line_ok, line_empty, is_digit;
  logic [COORD_WIDTH-1:0]             x0, y0, x1, y1;
  logic [INSTRUCTION_WIDTH-1:0]       word;

  assign is_digit = (inbound_data >= CH_0) && (inbound_data <= CH_9);

  always_comb begin
    fld_close = fld_q;
    idx_close = idx_q;
    if (ndig_q != 3'd0 && !idx_q[2]) begin
      fld_close[idx_q[1:0]] = acc_q[COORD_WIDTH-1:0];
      idx_close             = idx_q + 3'd1;
    end
    line_ok    = (idx_close == 3'd4) && (op_q != 2'b00);
    line_empty = (state_q == S_OP) && (k_q == 4'd0);
`ifdef INSTR_NORMALIZE_EN
    x0 = (fld_close[0] < fld_close[2]) ? fld_close[0] : fld_close[2];
    x1 = (fld_close[0] < fld_close[2]) ? fld_close[2] : fld_close[0];
    y0 = (fld_close[1] < fld_close[3]) ? fld_close[1] : fld_close[3];
    y1 = (fld_close[1] < fld_close[3]) ? fld_close[3] : fld_close[1];
`else
    x0 = fld_close[0];
    y0 = fld_close[1];
    x1 = fld_close[2];
    y1 = fld_close[3];
`endif
    word = {op_q, x0, y0, x1, y1, 2'b00};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    turn_d  = turn_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    idx_d   = idx_q;
    fld_d   = fld_q;
    eof_d   = eof_q;
    err_d   = err_q;
    valid_d = 1'b0;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (inbound_valid && state_q != S_DONE && inbound_data != CH_CR) begin
      if (inbound_data == CH_LF || inbound_data == CH_NUL) begin
        // NUL behaves like LF for the pending line, then stops the parser.
        if (state_q != S_SKIP) begin
          if (line_ok) begin
            valid_d = 1'b1;
            data_d  = word;
            cnt_d   = cnt_q + 1'b1;
          end else if (!line_empty) begin
            err_d = 1'b1;
          end
        end
        k_d    = '0;
        op_d   = '0;
        turn_d = 1'b0;
        acc_d  = '0;
        ndig_d = '0;
        idx_d  = '0;
        if (inbound_data == CH_NUL) begin
          eof_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_OP;
        end
      end else begin
        case (state_q)
          S_OP: begin
            if (is_digit) begin
              state_d = S_NUM;
              acc_d   = AW'(inbound_data[3:0]);
              ndig_d  = 3'd1;
              idx_d   = '0;
            end else begin
              if (k_q != '1) k_d = k_q + 4'd1;
              if (k_q == 4'd1) begin
                if (inbound_data == CH_O)      op_d   = 2'b11;
                else if (inbound_data == CH_U) turn_d = 1'b1;
                else begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end
              end else if (k_q == 4'd6 && turn_q) begin
                if (inbound_data == CH_N)      op_d = 2'b01;
                else if (inbound_data == CH_F) op_d = 2'b10;
                else begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end
              end
            end
          end
          S_NUM: begin
            if (is_digit) begin
              // A digit opening a 5th field, or a 5th digit in a field, is fatal.
              if ((ndig_q == 3'd0 && idx_q == 3'd4) || ndig_q == 3'd4) begin
                err_d   = 1'b1;
                state_d = S_SKIP;
              end else begin
                acc_d  = (acc_q << 3) + (acc_q << 1) + AW'(inbound_data[3:0]);
                ndig_d = ndig_q + 3'd1;
              end
            end else if (ndig_q != 3'd0) begin
              fld_d[idx_q[1:0]] = acc_q[COORD_WIDTH-1:0];
              idx_d  = idx_q + 3'd1;
              acc_d  = '0;
              ndig_d = '0;
            end
          end
          default: ;  // S_SKIP waits for LF/NUL; S_DONE never reaches here
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_OP;
      k_q     <= '0;
      op_q    <= '0;
      turn_q  <= 1'b0;
      acc_q   <= '0;
      ndig_q  <= '0;
      idx_q   <= '0;
      fld_q   <= '0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      turn_q  <= turn_d;
      acc_q   <= acc_d;
      ndig_q  <= ndig_d;
      idx_q   <= idx_d;
      fld_q   <= fld_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign end_of_file  = eof_q;
  assign instr_valid  = valid_q;
  assign instr_data   = data_q;
  assign format_error = err_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_instr_ascii_parser.sv
// -----------------------------------------------------------------------------
// tb_instr_ascii_parser
//   Self-checking bench for instr_ascii_parser. A string-level reference model
//   decides, per whole line, whether it is empty, well formed or malformed and
//   what instruction word it yields. Directed lines come first, then a random
//   stream of well formed and malformed lines (with optional CRs).
// -----------------------------------------------------------------------------
module tb_instr_ascii_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inbound_valid = 1'b0;
  logic [7:0]  inbound_data = 8'h00;
  logic        end_of_file;
  logic        instr_valid;
  logic [51:0] instr_data;
  logic        format_error;
  logic [15:0] instr_count;

  int passed = 0;
  int total  = 0;

  // Model state
  int          exp_count;
  bit          exp_err;
  bit          exp_eof;

  instr_ascii_parser #(
    .INBOUND_DATA_WIDTH(8),
    .COORD_WIDTH(12),
    .INSTRUCTION_WIDTH(52),
    .COUNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inbound_valid(inbound_valid),
    .inbound_data(inbound_data),
    .end_of_file(end_of_file),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .format_error(format_error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [51:0] mk(input int op, input int a, input int b,
                                     input int c, input int d);
    return {op[1:0], a[11:0], b[11:0], c[11:0], d[11:0], 2'b00};
  endfunction

  // kind: 0 empty, 1 well formed, 2 malformed
  function automatic void model_line(input string s, output int kind,
                                     output logic [51:0] w);
    string t;
    int    runs[$];
    int    cur, cur_len, first, pre_len, op;
    bit    err, turn;
    byte   c;
    int    xa, ya, xb, yb;
    t = ""; cur = 0; cur_len = 0; first = -1; err = 0; turn = 0; op = 0;
    w = '0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != 8'h0D) t = {t, s.substr(i, i)};
    if (t.len() == 0) begin
      kind = 0;
      return;
    end
    for (int i = 0; i <= t.len(); i++) begin
      c = (i < t.len()) ? t[i] : 8'h20;
      if (c >= "0" && c <= "9") begin
        if (first < 0) first = i;
        cur = cur * 10 + int'(c) - 48;
        cur_len++;
      end else if (cur_len > 0) begin
        if (cur_len > 4) err = 1;
        runs.push_back(cur);
        cur = 0;
        cur_len = 0;
      end
    end
    pre_len = (first < 0) ? t.len() : first;
    if (pre_len > 1) begin
      if (t[1] == "o") op = 3;
      else if (t[1] == "u") turn = 1;
      else err = 1;
    end
    if (turn && pre_len > 6) begin
      if (t[6] == "n") op = 1;
      else if (t[6] == "f") op = 2;
      else err = 1;
    end
    if (err || op == 0 || runs.size() != 4) begin
      kind = 2;
      return;
    end
    kind = 1;
    xa = runs[0]; ya = runs[1]; xb = runs[2]; yb = runs[3];
`ifdef INSTR_NORMALIZE_EN
    w = mk(op, (xa < xb) ? xa : xb, (ya < yb) ? ya : yb,
               (xa < xb) ? xb : xa, (ya < yb) ? yb : ya);
`else
    w = mk(op, xa, ya, xb, yb);
`endif
  endfunction

  task automatic send_byte(input byte c);
    inbound_valid = 1'b1;
    inbound_data  = c;
    @(posedge clk);
    #1;
    inbound_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inbound_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    exp_err   = 0;
    exp_eof   = 0;
  endtask

  // Sends s followed by terminator term (LF or NUL) back to back and checks
  // the line result right after the terminator is accepted.
  task automatic send_line(input string s, input byte term, input string tag);
    int          kind;
    logic [51:0] w;
    int          spurious;
    bit          want;
    spurious = 0;
    model_line(s, kind, w);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (instr_valid) spurious++;
    end
    send_byte(term);
    want = !exp_eof && kind == 1;
    if (!exp_eof) begin
      if (kind == 1) exp_count++;
      if (kind == 2) exp_err = 1;
      if (term == 8'h00) exp_eof = 1;
    end
    total++;
    if (instr_valid !== want) $display("FAIL %s valid: got %b want %b", tag, instr_valid, want);
    else passed++;
    if (want) begin
      total++;
      if (instr_data !== w) $display("FAIL %s data: got %h want %h", tag, instr_data, w);
      else passed++;
    end
    total++;
    if (instr_count !== 16'(exp_count))
      $display("FAIL %s count: got %0d want %0d", tag, instr_count, exp_count);
    else passed++;
    total++;
    if (format_error !== exp_err) $display("FAIL %s format_error: got %b want %b", tag, format_error, exp_err);
    else passed++;
    total++;
    if (end_of_file !== exp_eof) $display("FAIL %s end_of_file: got %b want %b", tag, end_of_file, exp_eof);
    else passed++;
    total++;
    if (spurious != 0) $display("FAIL %s midline pulses: got %0d want 0", tag, spurious);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({end_of_file, instr_valid, format_error} !== 3'b000 || instr_data !== '0 || instr_count !== '0)
      $display("FAIL reset outputs: got eof=%b v=%b err=%b data=%h cnt=%0d want all 0",
               end_of_file, instr_valid, format_error, instr_data, instr_count);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    send_line("turn on 0,0 through 999,999", 8'h0A, "single");
    total++;
    if (instr_data !== {2'b01, 12'd0, 12'd0, 12'd999, 12'd999, 2'b00})
      $display("FAIL single word: got %h", instr_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_line("toggle 0,0 through 999,0", 8'h0A, "b2b1");
    total++;
    if (instr_data !== {2'b11, 12'd0, 12'd0, 12'd999, 12'd0, 2'b00})
      $display("FAIL b2b1 word: got %h", instr_data);
    else passed++;
    send_line("turn off 499,499 through 500,500", 8'h0A, "b2b2");
    total++;
    if (instr_data !== {2'b10, 12'd499, 12'd499, 12'd500, 12'd500, 2'b00} || instr_count !== 16'd2)
      $display("FAIL b2b2 word/count: got %h cnt %0d want count 2", instr_data, instr_count);
    else passed++;
  endtask

  task automatic test_errors();
    do_reset();
    send_line("turn up 1,2 through 3,4", 8'h0A, "err_op");
    total++;
    if (format_error !== 1'b1) $display("FAIL err_op flag: got %b want 1", format_error);
    else passed++;
    send_line("", 8'h0A, "err_empty");
    send_line("turn on 1,2 through 3", 8'h0A, "err_3f");
    send_line("toggle 1,2 through 3,4,5", 8'h0A, "err_5f");
    send_line("toggle 12345,2 through 3,4", 8'h0A, "err_5d");
    total++;
    if (instr_count !== 16'd0) $display("FAIL err count: got %0d want 0", instr_count);
    else passed++;
  endtask

  task automatic test_eof();
    do_reset();
    send_line("toggle 5,6 through 7,8", 8'h00, "eof_emit");
    total++;
    if (instr_data !== {2'b11, 12'd5, 12'd6, 12'd7, 12'd8, 2'b00} || end_of_file !== 1'b1)
      $display("FAIL eof word: got %h eof %b", instr_data, end_of_file);
    else passed++;
    send_line("turn on 1,1 through 2,2", 8'h0A, "eof_ignore");
    total++;
    if (instr_count !== 16'd1 || end_of_file !== 1'b1)
      $display("FAIL eof sticky: got cnt %0d eof %b want 1 1", instr_count, end_of_file);
    else passed++;
  endtask

  task automatic test_async_reset();
    string part;
    do_reset();
    send_line("toggle 1,2 through 3,4", 8'h0A, "ar_pre");
    part = "turn off 12,3";
    for (int i = 0; i < part.len(); i++) send_byte(part[i]);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({end_of_file, instr_valid, format_error} !== 3'b000 || instr_data !== '0 || instr_count !== '0)
      $display("FAIL async reset: got eof=%b v=%b err=%b data=%h cnt=%0d want all 0",
               end_of_file, instr_valid, format_error, instr_data, instr_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    exp_err   = 0;
    exp_eof   = 0;
    send_line("toggle 1,1 through 2,2", 8'h0A, "ar_post");
    total++;
    if (instr_data !== {2'b11, 12'd1, 12'd1, 12'd2, 12'd2, 2'b00})
      $display("FAIL ar_post word: got %h", instr_data);
    else passed++;
  endtask

  task automatic test_normalize();
    logic [51:0] w;
    do_reset();
`ifdef INSTR_NORMALIZE_EN
    w = {2'b01, 12'd1, 12'd2, 12'd9, 12'd8, 2'b00};
`else
    w = {2'b01, 12'd9, 12'd8, 12'd1, 12'd2, 2'b00};
`endif
    send_line("turn on 9,8 through 1,2", 8'h0A, "norm");
    total++;
    if (instr_data !== w) $display("FAIL norm word: got %h want %h", instr_data, w);
    else passed++;
  endtask

  function automatic string gen_line();
    string ops[3];
    string s;
    int    a, b, c, d, m;
    ops[0] = "turn on "; ops[1] = "turn off "; ops[2] = "toggle ";
    a = $urandom_range(999); b = $urandom_range(999);
    c = $urandom_range(999); d = $urandom_range(999);
    m = $urandom_range(19);
    case (m)
      0: s = $sformatf("turn up %0d,%0d through %0d,%0d", a, b, c, d);
      1: s = $sformatf("tarn on %0d,%0d through %0d,%0d", a, b, c, d);
      2: s = $sformatf("toggle %0d,%0d through %0d", a, b, c);
      3: s = $sformatf("toggle %0d,%0d through %0d,%0d,7", a, b, c, d);
      4: s = $sformatf("turn off %0d,%0d through 1%0d0000,%0d", a, b, c, d);
      5: s = "";
      default: s = $sformatf("%s%0d,%0d through %0d,%0d", ops[$urandom_range(2)], a, b, c, d);
    endcase
    if ($urandom_range(3) == 0) s = {s, "\015"};
    return s;
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 80; n++) send_line(gen_line(), 8'h0A, $sformatf("rand%0d", n));
    send_line(gen_line(), 8'h00, "rand_eof");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_eof();
    test_async_reset();
    test_normalize();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_ascii_parser.md
Name: instr_ascii_parser

Overview:
- Upstream parsing stage for the light-grid puzzle (2015 day 6).
- Consumes the deserialized ASCII byte stream from tap_decoder, one byte per inbound_valid. Each text line is parsed into a fixed-layout instruction word: opcode plus four coordinates.
- The instruction word feeds the per-instruction accumulation logic. The block also flags end of input and malformed lines.
- Runs entirely in the TCK domain.

Parameters:
- INBOUND_DATA_WIDTH, 8, width of one inbound character.
- COORD_WIDTH, 12, width of each binary coordinate field.
- INSTRUCTION_WIDTH, 52, equals 2 + 4*COORD_WIDTH + 2.
- COUNT_WIDTH, 16, width of instr_count.

Ports:
- clk  in  1  TCK.
- reset  in  1  asynchronous, active-high.
- inbound_valid  in  1  inbound_data holds a new character this cycle.
- inbound_data  in  8  ASCII character.
- end_of_file  out  1  sticky: set after the NUL terminator (0x00) is accepted.
- instr_valid  out  1  one-cycle pulse: instr_data is valid.
- instr_data  out  52  instruction word.
  - [51:50] opcode: 01 turn on, 10 turn off, 11 toggle.
  - [49:38] x0, [37:26] y0, [25:14] x1, [13:2] y1.
  - [1:0] always 0.
- format_error  out  1  sticky: set on any malformed line.
- instr_count  out  16  number of instr_valid pulses since reset; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync deassert by clk): state=S_OP, all outputs 0, all accumulators 0. A partial line in progress is discarded.
- State S_OP: track letter index k within the line; spaces are counted in k.
  - k=1: 'o' selects toggle, 'u' selects turn.
  - turn only, k=6: 'n' selects on, 'f' selects off.
  - First digit seen: goto S_NUM with field=0.
- State S_NUM: digit characters accumulate acc = acc*10 + (c-0x30).
  - A non-digit after at least one digit closes the field: store acc into field[idx], idx++, acc=0.
  - Letters, spaces and ',' between fields are skipped; this covers the word "through".
  - More than 4 digits in one field: error.
- Line feed (0x0A), any state:
  - Empty line (k=0, no digits): ignored silently.
  - Exactly 4 fields closed and opcode known: capture, next cycle instr_valid=1, instr_count++.
  - Otherwise: format_error<=1 and no instr_valid.
  - Then return to S_OP and clear the per-line state.
  - The 4th field closes on LF itself.
- Carriage return (0x0D) is ignored everywhere.
- Latency: instr_valid is registered, exactly 1 clk after the cycle in which the LF is accepted. instr_data holds its value until the next capture.
- Errors: unknown opcode letter, 5th field, or digit overflow.
  - Set format_error. State S_SKIP discards bytes until LF, then returns to S_OP.
  - No instruction is emitted for that line.
- NUL (0x00):
  - Sets end_of_file; state S_DONE.
  - A pending partial line with 4 closed fields (no trailing LF) is emitted exactly as if LF had been seen, in the same cycle end_of_file rises.
  - Any other partial line sets format_error.
- S_DONE: all further inbound bytes are ignored until reset.
- Back-to-back bytes at one per clk are accepted with no stall; the block has no backpressure.
- Coordinates are binary and zero-extended; the maximum legal value is 999.

Optional Feature:
- Macro: INSTR_NORMALIZE_EN.
- Defined: at capture, emit x0=min(xa,xb), x1=max(xa,xb), y0=min(ya,yb), y1=max(ya,yb). The compare is done in the capture cycle, so latency is unchanged.
- Undefined: fields are emitted in parse order, unmodified.

Test Plan:
- "turn on 0,0 through 999,999\n" -> one instr_valid 1 clk after LF; opcode=01, x0=0, y0=0, x1=999, y1=999, [1:0]=0; instr_count=1.
- "toggle 0,0 through 999,0\nturn off 499,499 through 500,500\n", bytes back-to-back:
  - two pulses: {11,0,0,999,0} then {10,499,499,500,500};
  - instr_count=2; format_error=0.
- "turn up 1,2 through 3,4\n\nturn on 1,2 through 3\n" -> no instr_valid; format_error=1 after the first line; empty line ignored; instr_count=0.
- "toggle 5,6 through 7,8" then 0x00, no LF:
  - instr_valid pulses, {11,5,6,7,8};
  - end_of_file=1 and stays 1;
  - a following "turn on 1,1 through 2,2\n" produces nothing.
- Async reset asserted midway through "turn off 12,3" -> all outputs 0 immediately. After release, "toggle 1,1 through 2,2\n" yields {11,1,1,2,2}, with no residue from the aborted line.
- With INSTR_NORMALIZE_EN: "turn on 9,8 through 1,2\n" -> {01,1,2,9,8}. Without it -> {01,9,8,1,2}.
